// File: rtl/gpr_wb_scheduler.sv
// GPR write-port scheduler: round-robin ALU/load writeback arbitration, busy scoreboard, RAW/WAW issue stall.
// Latency: one cycle from an accepted writeback to the registered GPR write strobe.
// Backpressure: the loser of a contest sees ready low; issue stalls while a source or destination is busy.
// GPR_WB_FWD_EN adds a forwarding bus and masks hazards on the register currently being written.
module gpr_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        iss_rs1,
    input  logic [AW-1:0]        iss_rs2,
    output logic                 iss_ready,
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_rd,
    input  logic [XLEN-1:0]      req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_rd,
    input  logic [XLEN-1:0]      req1_data,
    output logic                 req1_ready,
    output logic                 gpr_reg_write,
    output logic [AW-1:0]        gpr_rd,
    output logic [XLEN-1:0]      gpr_write_data,
`ifdef GPR_WB_FWD_EN
    output logic                 fwd_valid,
    output logic [AW-1:0]        fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
`endif
    output logic [(2**AW)-1:0]   busy_vec
);
    localparam int NREG = 2**AW;

    logic            last_grant_q, last_grant_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            gnt0, gnt1;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            haz_rs1, haz_rs2, haz_rd;
    logic            fwd_hit;

    // last_grant_q == 1 means req1 won most recently, so req0 wins the next contest.
    always_comb begin
        gnt0         = req0_valid && (!req1_valid || last_grant_q);
        gnt1         = req1_valid && (!req0_valid || !last_grant_q);
        last_grant_d = last_grant_q;
        wb_rd        = '0;
        wb_data      = '0;
        if (gnt0) begin
            last_grant_d = 1'b0;
            wb_rd        = req0_rd;
            wb_data      = req0_data;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
            wb_rd        = req1_rd;
            wb_data      = req1_data;
        end
        wr_d   = (gnt0 || gnt1) && (wb_rd != '0);
        rd_d   = wr_d ? wb_rd : rd_q;
        data_d = wr_d ? wb_data : data_q;
    end

    always_comb begin
        fwd_hit = wr_q && (rd_q != '0);
`ifdef GPR_WB_FWD_EN
        haz_rs1 = busy_q[iss_rs1] && !(fwd_hit && (iss_rs1 == rd_q));
        haz_rs2 = busy_q[iss_rs2] && !(fwd_hit && (iss_rs2 == rd_q));
        haz_rd  = busy_q[iss_rd]  && !(fwd_hit && (iss_rd  == rd_q));
`else
        haz_rs1 = busy_q[iss_rs1];
        haz_rs2 = busy_q[iss_rs2];
        haz_rd  = busy_q[iss_rd];
`endif
        iss_ready = !(haz_rs1 || haz_rs2 || haz_rd);
        // Clear first so that a same-register set in this cycle wins.
        busy_d = busy_q;
        if (fwd_hit) begin
            busy_d[rd_q] = 1'b0;
        end
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready     = gnt0;
    assign req1_ready     = gnt1;
    assign gpr_reg_write  = wr_q;
    assign gpr_rd         = rd_q;
    assign gpr_write_data = data_q;
    assign busy_vec       = busy_q;
`ifdef GPR_WB_FWD_EN
    assign fwd_valid      = fwd_hit;
    assign fwd_rd         = rd_q;
    assign fwd_data       = data_q;
`endif
endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Directed bench for gpr_wb_scheduler: reset, contention, RAW/WAW stalls, x0 handling, mid-flight reset.
module tb_gpr_wb_scheduler;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
    logic            iss_ready;
    logic            req0_valid, req1_valid;
    logic [AW-1:0]   req0_rd, req1_rd;
    logic [XLEN-1:0] req0_data, req1_data;
    logic            req0_ready, req1_ready;
    logic            gpr_reg_write;
    logic [AW-1:0]   gpr_rd;
    logic [XLEN-1:0] gpr_write_data;
    logic [31:0]     busy_vec;
`ifdef GPR_WB_FWD_EN
    logic            fwd_valid;
    logic [AW-1:0]   fwd_rd;
    logic [XLEN-1:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    gpr_wb_scheduler #(.XLEN(XLEN), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_ready(iss_ready),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .gpr_reg_write(gpr_reg_write), .gpr_rd(gpr_rd), .gpr_write_data(gpr_write_data),
`ifdef GPR_WB_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .busy_vec(busy_vec)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later still.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Writes one value through req1 and waits until its busy bit (if any) has cleared.
    task automatic drain(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        req1_valid = 1'b1; req1_rd = rd; req1_data = data;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h1234_5678;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        tick();
        tick();
        settle();
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want %h", busy_vec, 32'h0); end
        n_checks++; if (gpr_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", gpr_reg_write); end
        n_checks++; if (gpr_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", gpr_rd); end
        n_checks++; if (gpr_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", gpr_write_data); end
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hAAAA_0005;
        req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'hBBBB_0006;
        settle();
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL cont_c1_r0: got %b want 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_c1_r1: got %b want 0", req1_ready); end
        tick();
        settle();
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL cont_c2_r1: got %b want 1", req1_ready); end
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL cont_c2_r0: got %b want 0", req0_ready); end
        n_checks++; if (gpr_reg_write !== 1'b1 || gpr_rd !== 5'd5 || gpr_write_data !== 32'hAAAA_0005) begin
            n_fail++; $display("FAIL cont_wr1: got %b/%0d/%h want 1/5/aaaa0005", gpr_reg_write, gpr_rd, gpr_write_data);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        settle();
        n_checks++; if (gpr_reg_write !== 1'b1 || gpr_rd !== 5'd6 || gpr_write_data !== 32'hBBBB_0006) begin
            n_fail++; $display("FAIL cont_wr2: got %b/%0d/%h want 1/6/bbbb0006", gpr_reg_write, gpr_rd, gpr_write_data);
        end
        tick();
        settle();
        n_checks++; if (gpr_reg_write !== 1'b0 || gpr_rd !== 5'd6 || gpr_write_data !== 32'hBBBB_0006) begin
            n_fail++; $display("FAIL cont_idle_hold: got %b/%0d/%h want 0/6/bbbb0006", gpr_reg_write, gpr_rd, gpr_write_data);
        end
    endtask

    task automatic test_raw();
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        settle();
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready: got %b want 1", iss_ready); end
        tick();
        iss_rd = 5'd8; iss_rs1 = 5'd7;
        settle();
        n_checks++; if (busy_vec !== 32'h0000_0080) begin n_fail++; $display("FAIL raw_busy7: got %h want 00000080", busy_vec); end
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall1: got %b want 0", iss_ready); end
        tick();
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7777_0007;
        settle();
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall2: got %b want 0", iss_ready); end
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL raw_req0_ready: got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        settle();
        n_checks++; if (gpr_reg_write !== 1'b1 || gpr_rd !== 5'd7 || gpr_write_data !== 32'h7777_0007) begin
            n_fail++; $display("FAIL raw_wr: got %b/%0d/%h want 1/7/77770007", gpr_reg_write, gpr_rd, gpr_write_data);
        end
`ifdef GPR_WB_FWD_EN
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_fwd_ready: got %b want 1", iss_ready); end
        n_checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'h7777_0007) begin
            n_fail++; $display("FAIL raw_fwd_bus: got %b/%0d/%h want 1/7/77770007", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
`else
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_wrcycle: got %b want 0", iss_ready); end
        tick();
        settle();
        n_checks++; if (iss_ready !== 1'b1 || busy_vec[7] !== 1'b0) begin
            n_fail++; $display("FAIL raw_release: got ready=%b busy7=%b want 1/0", iss_ready, busy_vec[7]);
        end
        tick();
`endif
        iss_valid = 1'b0;
        settle();
        n_checks++; if (busy_vec !== 32'h0000_0100) begin n_fail++; $display("FAIL raw_busy8: got %h want 00000100", busy_vec); end
        drain(5'd8, 32'h8888_0008);
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_drained: got %h want 0", busy_vec); end
    endtask

    task automatic test_waw();
        iss_valid = 1'b1; iss_rd = 5'd9; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        tick();
        settle();
        n_checks++; if (busy_vec !== 32'h0000_0200) begin n_fail++; $display("FAIL waw_busy9: got %h want 00000200", busy_vec); end
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", iss_ready); end
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h9999_0009;
        tick();
        req0_valid = 1'b0;
        settle();
`ifdef GPR_WB_FWD_EN
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL waw_fwd_ready: got %b want 1", iss_ready); end
        tick();
`else
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall_wrcycle: got %b want 0", iss_ready); end
        tick();
        settle();
        n_checks++; if (iss_ready !== 1'b1 || busy_vec !== 32'h0) begin
            n_fail++; $display("FAIL waw_release: got ready=%b busy=%h want 1/0", iss_ready, busy_vec);
        end
        tick();
`endif
        iss_valid = 1'b0;
        settle();
        n_checks++; if (busy_vec !== 32'h0000_0200) begin n_fail++; $display("FAIL waw_reissued: got %h want 00000200", busy_vec); end
        drain(5'd9, 32'h9999_1009);
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL waw_drained: got %h want 0", busy_vec); end
    endtask

    task automatic test_x0();
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        settle();
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_iss_ready: got %b want 1", iss_ready); end
        tick();
        iss_valid = 1'b0;
        settle();
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h want 0", busy_vec); end
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hFFFF_FFFF;
        settle();
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL x0_req1_ready: got %b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        settle();
        n_checks++; if (gpr_reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: got %b want 0", gpr_reg_write); end
        tick();
    endtask

    task automatic test_reset_midflight();
        iss_valid = 1'b1; iss_rd = 5'd3; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        tick();
        iss_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'h0A0A_000A;
        settle();
        n_checks++; if (busy_vec !== 32'h0000_0008) begin n_fail++; $display("FAIL mid_busy3: got %h want 00000008", busy_vec); end
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_req0_ready: got %b want 1", req0_ready); end
        reset = 1'b0;
        tick();
        req0_valid = 1'b0;
        settle();
        n_checks++; if (gpr_reg_write !== 1'b0) begin n_fail++; $display("FAIL mid_wr: got %b want 0", gpr_reg_write); end
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL mid_busy: got %h want 0", busy_vec); end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_raw();
        test_waw();
        test_x0();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_wb_scheduler.md
Name: gpr_wb_scheduler

Overview:
- Schedules all writes into the 32-entry general-purpose register file.
- Arbitrates the GPR's single write port between two writeback requesters: req0 = ALU, req1 = load unit.
- Keeps a per-register busy scoreboard, and stalls issue on RAW/WAW hazards against writes still in flight.
- Sits between the issue stage, the execution units and the GPR write port (reg_write / rd / write_data).

Parameters:
- XLEN, 32, data width of writeback values.
- AW, 5, register address width; NREG = 2**AW registers.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- iss_valid  in  1  issue stage presents an instruction.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_rs1  in  AW  source register 1 of the issuing instruction.
- iss_rs2  in  AW  source register 2 of the issuing instruction.
- iss_ready  out  1  high = no hazard; issue fires on iss_valid && iss_ready.
- req0_valid  in  1  ALU writeback request.
- req0_rd  in  AW  ALU destination register.
- req0_data  in  XLEN  ALU result.
- req0_ready  out  1  ALU request granted this cycle.
- req1_valid  in  1  load-unit writeback request.
- req1_rd  in  AW  load destination register.
- req1_data  in  XLEN  load data.
- req1_ready  out  1  load request granted this cycle.
- gpr_reg_write  out  1  GPR write strobe (registered).
- gpr_rd  out  AW  GPR write address (registered).
- gpr_write_data  out  XLEN  GPR write data (registered).
- busy_vec  out  NREG  scoreboard; bit i = register i has a write pending.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge):
  - busy_vec=0, gpr_reg_write=0, gpr_rd=0, gpr_write_data=0, last_grant=1 (req0 wins first contest).
  - Reset mid-operation discards any registered write and all busy bits.
- Arbitration (combinational):
  - Only one valid requester: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = grant for N; a transfer happens on reqN_valid && reqN_ready.
  - last_grant updates to the winner at the edge of the transfer; it holds when no transfer occurs.
  - Requesters hold valid, rd and data stable until ready. Dropping valid without ready is illegal.
- Write stage, 1-cycle latency:
  - Transfer in cycle N drives gpr_reg_write=1 with gpr_rd / gpr_write_data during cycle N+1.
  - The GPR commits the write at the end of N+1.
  - No transfer in N: gpr_reg_write=0 in N+1; gpr_rd and gpr_write_data hold their previous values.
  - Transfer with rd==0: accepted (ready high) but gpr_reg_write stays 0.
  - Back-to-back transfers are allowed, giving one write per cycle.
- Scoreboard:
  - Issue fire with iss_rd!=0 sets busy[iss_rd] at that edge.
  - An edge with gpr_reg_write=1 clears busy[gpr_rd].
  - busy[0] is constant 0.
  - A writeback to a non-busy register is still written and leaves busy unchanged.
- Hazard: iss_ready = !(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]).
  - Checks use the current busy_vec: a register being cleared this cycle still stalls.
  - iss_ready is computed regardless of iss_valid.
- Same-register set and clear on one edge cannot occur (the WAW stall prevents it). Sets and clears to different registers on the same edge both apply.

Optional Feature:
- Macro: GPR_WB_FWD_EN.
- Defined:
  - Extra outputs fwd_valid (1), fwd_rd (AW) and fwd_data (XLEN), equal to gpr_reg_write && gpr_rd!=0, gpr_rd and gpr_write_data.
  - Any hazard term whose register equals gpr_rd while fwd_valid=1 is masked, so issue proceeds and takes its operand from the fwd bus.
  - An issue to that same rd in that cycle sets busy (set wins over clear).
- Undefined: fwd ports are absent; hazard logic is exactly as in Behaviour.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req0_valid=1 -> busy_vec=0, gpr_reg_write=0, gpr_rd=0, gpr_write_data=0. First contest after reset grants req0.
- Contention: req0 (rd=5, 0xAAAA0005) and req1 (rd=6, 0xBBBB0006) both valid for 2 cycles. Expected:
  - Cycle 1: req0_ready=1, req1_ready=0. Cycle 2: req1_ready=1.
  - gpr_reg_write=1 on cycles 2 and 3 with rd=5 then rd=6 and the matching data.
- RAW stall: issue rd=7 (fires, busy[7]=1). Next issue has rs1=7:
  - iss_ready=0 until a req0 write to rd=7 is on gpr_reg_write.
  - iss_ready=1 the cycle after that write, with busy[7]=0 (GPR_WB_FWD_EN defined: iss_ready=1 during the write cycle).
- WAW stall: issue rd=9, then issue rd=9 with rs1=rs2=0 -> second issue waits until busy[9] clears.
- x0 handling: issue rd=0 -> busy_vec unchanged. req1 valid with rd=0, data 0xFFFFFFFF -> req1_ready=1 and gpr_reg_write stays 0.
- Reset mid-flight: busy[3]=1 and a transfer accepted in cycle N, reset=0 at the end of N -> N+1 shows gpr_reg_write=0 and busy_vec=0.
